// File: rtl/gba_io_pkg.sv
// Shared types for the memory-port arbiter: transfer widths, FSM states and
// default bus sizes.
package gba_io_pkg;

    localparam int AW_DEF = 26;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        W_ILLEGAL = 2'b00,
        W8        = 2'b01,
        W16       = 2'b10,
        W32       = 2'b11
    } width_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE_RD,
        ST_DONE_WR
    } state_e;

    // An unset width code is treated as a full-word transfer.
    function automatic width_e legal_width(input logic [1:0] w);
        return (w == 2'b00) ? W32 : width_e'(w);
    endfunction

endpackage

// File: rtl/mem_mux_arbiter_if.sv
// Single memory port shared by all requester channels; master = arbiter,
// slave = memory controller.
interface mem_mux_arbiter_if
    import gba_io_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          mem_rd;
    logic          mem_wr;
    logic [1:0]    mem_data_width;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_ready;
    logic          mem_wr_ready;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_valid;

    modport master (
        output mem_rd, mem_wr, mem_data_width, mem_addr, mem_wr_data,
        input  mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid
    );

    modport slave (
        input  mem_rd, mem_wr, mem_data_width, mem_addr, mem_wr_data,
        output mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins,
// returned both one-hot and as an index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        int   k;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/mem_mux_arbiter.sv
// N-channel arbiter onto a single memory port, one transaction in flight.
// Define ARB_CH0_PRIO_EN to give channel 0 absolute priority over the others.
module mem_mux_arbiter
    import gba_io_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      ch_rd,
    input  logic [N_CH-1:0]      ch_wr,
    input  logic [2*N_CH-1:0]    ch_width,
    input  logic [AW*N_CH-1:0]   ch_addr,
    input  logic [DW*N_CH-1:0]   ch_wr_data,
    output logic [DW-1:0]        ch_rd_data,
    output logic [N_CH-1:0]      ch_rd_valid,
    output logic [N_CH-1:0]      ch_wr_done,
    mem_mux_arbiter_if.master    mem
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e          state;
    logic [IW-1:0]   rr_ptr;
    logic [N_CH-1:0] own_oh;

    logic [N_CH-1:0] req;
    logic [N_CH-1:0] rr_req;
    logic [N_CH-1:0] rr_grant;
    logic [N_CH-1:0] win_oh;
    logic [IW-1:0]   rr_idx;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   next_ptr;

    logic            sel_rd;
    logic [1:0]      sel_width;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    assign req = ch_rd | ch_wr;

`ifdef ARB_CH0_PRIO_EN
    // Channel 0 bypasses the rotation; the picker only ever sees 1..N_CH-1.
    assign rr_req  = {req[N_CH-1:1], 1'b0};
    assign win_oh  = req[0] ? N_CH'(1) : rr_grant;
    assign win_idx = req[0] ? '0 : rr_idx;
`else
    assign rr_req  = req;
    assign win_oh  = rr_grant;
    assign win_idx = rr_idx;
`endif

    rr_pick #(.N(N_CH), .IW(IW)) u_rr_pick (
        .req   (rr_req),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    assign next_ptr = (win_idx == IW'(N_CH - 1)) ? '0 : win_idx + IW'(1);

    always_comb begin
        sel_rd    = 1'b0;
        sel_width = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (win_oh[i]) begin
                sel_rd    = ch_rd[i];
                sel_width = ch_width[2*i +: 2];
                sel_addr  = ch_addr[AW*i +: AW];
                sel_wdata = ch_wr_data[DW*i +: DW];
            end
        end
    end

    function automatic logic [DW-1:0] width_mask(input width_e w, input logic [DW-1:0] d);
        case (w)
            W8:      return d & DW'(8'hFF);
            W16:     return d & DW'(16'hFFFF);
            default: return d;
        endcase
    endfunction

    // Ack pulses default low every cycle and are raised only on the edge
    // that enters the matching DONE state, so they last exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            rr_ptr             <= '0;
            own_oh             <= '0;
            mem.mem_rd         <= 1'b0;
            mem.mem_wr         <= 1'b0;
            mem.mem_data_width <= '0;
            mem.mem_addr       <= '0;
            mem.mem_wr_data    <= '0;
            ch_rd_data         <= '0;
            ch_rd_valid        <= '0;
            ch_wr_done         <= '0;
        end else begin
            ch_rd_valid <= '0;
            ch_wr_done  <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        own_oh             <= win_oh;
                        rr_ptr             <= next_ptr;
                        mem.mem_rd         <= sel_rd;
                        mem.mem_wr         <= !sel_rd;
                        mem.mem_data_width <= legal_width(sel_width);
                        mem.mem_addr       <= sel_addr;
                        mem.mem_wr_data    <= sel_wdata;
                        state              <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem.mem_rd && mem.mem_rd_ready) begin
                        mem.mem_rd <= 1'b0;
                        state      <= ST_WAIT;
                    end else if (mem.mem_wr && mem.mem_wr_ready) begin
                        mem.mem_wr <= 1'b0;
                        ch_wr_done <= own_oh;
                        state      <= ST_DONE_WR;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_rd_valid) begin
                        ch_rd_data  <= width_mask(width_e'(mem.mem_data_width), mem.mem_rd_data);
                        ch_rd_valid <= own_oh;
                        state       <= ST_DONE_RD;
                    end
                end
                ST_DONE_RD, ST_DONE_WR: state <= ST_IDLE;
                default:                state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_mux_arbiter.sv
// Scoreboard bench for mem_mux_arbiter: stimulus pushes expected acks, a
// negedge monitor pops and compares every ack pulse the DUT produces.
module tb_mem_mux_arbiter;
    import gba_io_pkg::*;

    localparam int N_CH = 2;
    localparam int AW   = 26;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_CH-1:0]      ch_rd;
    logic [N_CH-1:0]      ch_wr;
    logic [2*N_CH-1:0]    ch_width;
    logic [AW*N_CH-1:0]   ch_addr;
    logic [DW*N_CH-1:0]   ch_wr_data;
    logic [DW-1:0]        ch_rd_data;
    logic [N_CH-1:0]      ch_rd_valid;
    logic [N_CH-1:0]      ch_wr_done;

    mem_mux_arbiter_if #(.AW(AW), .DW(DW)) mem_if ();

    mem_mux_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_rd       (ch_rd),
        .ch_wr       (ch_wr),
        .ch_width    (ch_width),
        .ch_addr     (ch_addr),
        .ch_wr_data  (ch_wr_data),
        .ch_rd_data  (ch_rd_data),
        .ch_rd_valid (ch_rd_valid),
        .ch_wr_done  (ch_wr_done),
        .mem         (mem_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears one cycle after the accepting edge.
    logic          model_valid;
    logic [DW-1:0] model_data;
    logic          inject_valid = 1'b0;
    logic [DW-1:0] inject_data  = '0;
    bit            use_fixed    = 1'b1;
    logic [DW-1:0] fixed_val    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_valid <= 1'b0;
            model_data  <= '0;
        end else begin
            model_valid <= mem_if.mem_rd && mem_if.mem_rd_ready;
            if (mem_if.mem_rd && mem_if.mem_rd_ready)
                model_data <= use_fixed ? fixed_val : (32'h5A00_0000 | 32'(mem_if.mem_addr));
        end
    end

    assign mem_if.mem_rd_valid = model_valid | inject_valid;
    assign mem_if.mem_rd_data  = inject_valid ? inject_data : model_data;

    typedef struct {
        bit              is_rd;
        logic [N_CH-1:0] oh;
        logic [DW-1:0]   data;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, "_ctrl"}, {mem_if.mem_rd, mem_if.mem_wr, mem_if.mem_data_width, ch_rd_valid, ch_wr_done}, 64'h0);
        checkOutput({tag, "_addr"}, 64'(mem_if.mem_addr), 64'h0);
        checkOutput({tag, "_wdata"}, 64'(mem_if.mem_wr_data), 64'h0);
        checkOutput({tag, "_rdata"}, 64'(ch_rd_data), 64'h0);
    endtask

    // Monitor: every ack pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (ch_rd_valid != '0 || ch_wr_done != '0)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_ack: rd_valid=%b wr_done=%b, expected none (cycle %0d)", ch_rd_valid, ch_wr_done, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("ack_rd_valid", 64'(ch_rd_valid), e.is_rd ? 64'(e.oh) : 64'h0);
                checkOutput("ack_wr_done", 64'(ch_wr_done), e.is_rd ? 64'h0 : 64'(e.oh));
                if (e.is_rd)
                    checkOutput("ack_rd_data", 64'(ch_rd_data), 64'(e.data));
                checkOutput("ack_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // One transaction on one channel; stall holds the matching ready low for
    // that many cycles, drop_early releases the request right after accept.
    task automatic applyStimulus(input bit is_rd, input int ch, input logic [AW-1:0] addr,
                                 input logic [1:0] width, input logic [DW-1:0] wdata,
                                 input logic [DW-1:0] exp_rdata, input int stall, input bit drop_early);
        exp_t       e;
        int         t0;
        logic [1:0] exp_w;
        bit         acked;
        @(negedge clk);
        exp_w = (width == 2'b00) ? 2'b11 : width;
        if (stall > 0) begin
            if (is_rd) mem_if.mem_rd_ready = 1'b0;
            else       mem_if.mem_wr_ready = 1'b0;
        end
        ch_width[2*ch +: 2]    = width;
        ch_addr[AW*ch +: AW]   = addr;
        ch_wr_data[DW*ch +: DW] = wdata;
        if (is_rd) ch_rd[ch] = 1'b1;
        else       ch_wr[ch] = 1'b1;
        t0      = cyc;
        e.is_rd = is_rd;
        e.oh    = N_CH'(1) << ch;
        e.data  = is_rd ? exp_rdata : '0;
        e.cyc   = t0 + stall + (is_rd ? 3 : 2);
        exp_q.push_back(e);
        for (int k = 1; k <= stall + 1; k++) begin
            @(negedge clk);
            if (is_rd) checkOutput("issue_mem_rd", 64'(mem_if.mem_rd), 64'h1);
            else       checkOutput("issue_mem_wr", 64'(mem_if.mem_wr), 64'h1);
            checkOutput("issue_addr", 64'(mem_if.mem_addr), 64'(addr));
            checkOutput("issue_width", 64'(mem_if.mem_data_width), 64'(exp_w));
            if (!is_rd) checkOutput("issue_wdata", 64'(mem_if.mem_wr_data), 64'(wdata));
            if (k == stall + 1) begin
                mem_if.mem_rd_ready = 1'b1;
                mem_if.mem_wr_ready = 1'b1;
            end
        end
        if (drop_early) begin
            @(negedge clk);
            ch_rd[ch] = 1'b0;
            ch_wr[ch] = 1'b0;
        end
        acked = 1'b0;
        for (int k = 0; k < 20 && !acked; k++) begin
            @(negedge clk);
            if ((is_rd ? ch_rd_valid[ch] : ch_wr_done[ch]) === 1'b1) acked = 1'b1;
        end
        checkOutput("ack_seen", 64'(acked), 64'h1);
        ch_rd[ch] = 1'b0;
        ch_wr[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int pulses;
        exp_t e;
        logic [N_CH-1:0] order [4];

        ch_rd = '0;
        ch_wr = '0;
        ch_width = '0;
        ch_addr = '0;
        ch_wr_data = '0;
        mem_if.mem_rd_ready = 1'b1;
        mem_if.mem_wr_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        fixed_val = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 1, 26'h000_0100, 2'b11, '0, 32'hDEAD_BEEF, 0, 1'b0);

        fixed_val = 32'h1234_5678;
        applyStimulus(1'b1, 0, 26'h000_0200, 2'b01, '0, 32'h0000_0078, 0, 1'b0);
        applyStimulus(1'b1, 0, 26'h000_0204, 2'b10, '0, 32'h0000_5678, 0, 1'b0);
        applyStimulus(1'b1, 0, 26'h000_0208, 2'b00, '0, 32'h1234_5678, 0, 1'b0);

        applyStimulus(1'b0, 0, 26'h200_0010, 2'b01, 32'h0000_00AB, '0, 3, 1'b0);
        checkOutput("rd_data_hold", 64'(ch_rd_data), 64'h1234_5678);

        fixed_val = 32'hCAFE_F00D;
        applyStimulus(1'b1, 1, 26'h000_0300, 2'b10, '0, 32'h0000_F00D, 0, 1'b1);
        applyStimulus(1'b1, 0, 26'h000_0304, 2'b11, '0, 32'hCAFE_F00D, 0, 1'b0);

        @(negedge clk);
        inject_data  = 32'h1111_1111;
        inject_valid = 1'b1;
        @(negedge clk);
        inject_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stray_valid_ignored", 64'(ch_rd_data), 64'hCAFE_F00D);

        // Reset while the read sits in WAIT; no ack may leak out afterwards.
        @(negedge clk);
        ch_width[1:0]   = 2'b11;
        ch_addr[AW-1:0] = 26'h000_0040;
        ch_rd[0]        = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("wait_mem_rd_low", 64'(mem_if.mem_rd), 64'h0);
        rst_n = 1'b0;
        #1;
        check_quiet("reset_mid_wait");
        ch_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_quiet("after_reset");

        // Both channels requesting continuously.
        use_fixed = 1'b0;
`ifdef ARB_CH0_PRIO_EN
        order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        @(negedge clk);
        ch_width = 4'b1111;
        ch_addr[AW-1:0]    = 26'h000_0040;
        ch_addr[2*AW-1:AW] = 26'h000_0080;
        ch_rd = 2'b11;
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            e.is_rd = 1'b1;
            e.oh    = order[k];
            e.data  = (order[k] == 2'b01) ? 32'h5A00_0040 : 32'h5A00_0080;
            e.cyc   = t0 + 3 + 4 * k;
            exp_q.push_back(e);
        end
        pulses = 0;
        for (int k = 0; k < 40 && pulses < 4; k++) begin
            @(negedge clk);
            if (ch_rd_valid != '0) pulses++;
        end
        ch_rd = '0;
        checkOutput("alternation_acks", 64'(pulses), 64'd4);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_mux_arbiter.md
Name: mem_mux_arbiter

Overview:
- N-channel successor to the cart/USB mux front end: arbitrates N requesters (channel 0 = cart, channel 1 = USB, further channels for future DMA/debug) onto the single memory port.
- Fully parametrised in channel count, address width and data width.
- One outstanding memory transaction at a time; round-robin fairness; per-channel transfer width (8/16/32-bit) forwarded to memory.
- Read data is masked per width and returned to the owning channel only.

Parameters:
- N_CH, 2, number of requester channels (2..8)
- AW, 26, address width
- DW, 32, data width (memory side and per-channel bus)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ch_rd  in  N_CH  per-channel read request, level, held until acked
- ch_wr  in  N_CH  per-channel write request, level, held until acked
- ch_width  in  2*N_CH  per-channel width: 01=8b, 10=16b, 11=32b
- ch_addr  in  AW*N_CH  per-channel address
- ch_wr_data  in  DW*N_CH  per-channel write data, LSB-aligned
- ch_rd_data  out  DW  read data, shared, valid with ch_rd_valid
- ch_rd_valid  out  N_CH  one-cycle read-complete pulse (one-hot)
- ch_wr_done  out  N_CH  one-cycle write-complete pulse (one-hot)
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_data_width  out  2  width of current transfer
- mem_addr  out  AW  memory address
- mem_wr_data  out  DW  memory write data
- mem_rd_ready  in  1  memory accepts read this cycle
- mem_wr_ready  in  1  memory accepts write this cycle
- mem_rd_data  in  DW  memory read data
- mem_rd_valid  in  1  memory read data valid

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, rr pointer=0, latched channel fields cleared.
- FSM states and transitions:
  - IDLE: any channel with ch_rd|ch_wr → latch winner index, op, width, addr, wr_data → ISSUE.
  - ISSUE: mem_rd or mem_wr held high with latched fields (stable) until ready. Read accepted → WAIT; write accepted → DONE_WR.
  - WAIT: on mem_rd_valid, register masked data → DONE_RD.
  - DONE_RD: ch_rd_valid[idx]=1 for 1 cycle, ch_rd_data valid → IDLE.
  - DONE_WR: ch_wr_done[idx]=1 for 1 cycle → IDLE.
- Grant: round-robin starting at channel after last winner; pointer updates only on grant. Same channel with both rd and wr → read served first.
- Latency (ready tied high, memory valid 1 cycle after accept), request seen at cycle T:
  - mem_rd at T+1; ch_rd_valid at T+3.
  - mem_wr at T+1; ch_wr_done at T+2.
- Back-to-back: a request held through its ack cycle is re-arbitrated in the following IDLE cycle (min 1 idle cycle between transactions).
- Width masking of ch_rd_data: 01 → bits[7:0], 10 → [15:0], 11 → full DW; upper bits zero.
- ch_width=00 is illegal: transfer is issued as 11; no error flag.
- mem_rd_valid outside WAIT is ignored.
- Requester dropping its request mid-transaction: transaction completes, ack still pulses.
- ch_rd_data holds its last value between pulses.

Optional Feature:
- Macro ARB_CH0_PRIO_EN.
- Defined: channel 0 (cart, timing-critical) wins over all others whenever it requests in IDLE; round-robin applies among channels 1..N_CH-1 only.
- Undefined: pure round-robin over all N_CH channels.

Decomposition:
- Shared package gba_io_pkg:
  - width enum (W8=2'b01, W16=2'b10, W32=2'b11)
  - default AW/DW constants
  - FSM state enum
- One sub-module rr_pick: N-bit request vector plus pointer in; one-hot grant plus index out; combinational.

Test Plan:
- Reset mid-WAIT (rst_n low at T+2 of a read): all outputs 0 immediately; after release, FSM idle, no stray ch_rd_valid.
- Ch1 read addr 0x0000100, width 11, mem returns 0xDEADBEEF 1 cycle after accept → ch_rd_valid=2'b10 at T+3, ch_rd_data=0xDEADBEEF.
- Ch0 read width 01, mem returns 0x12345678 → ch_rd_data=0x00000078; width 10 → 0x00005678.
- Ch0 and ch1 requesting continuously, macro off → grants alternate 0,1,0,1; macro on → ch0 granted every transaction.
- Ch0 write addr 0x2000010, data 0xAB, width 01, mem_wr_ready low for 3 cycles → mem_wr/addr/data stable 4 cycles, ch_wr_done[0] one cycle after accept.
- Ch1 drops ch_rd after mem_rd accepted → ch_rd_valid[1] still pulses once; next grant proceeds normally.
